// File: rtl/xeng_pkg.sv
// Shared helpers for the X-engine baseline-order generator family.
package xeng_pkg;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned n_taps(input int unsigned n_ants);
    return n_ants / 2 + 1;
  endfunction

  function automatic int unsigned n_bls(input int unsigned n_ants);
    return n_ants * n_taps(n_ants);
  endfunction

  localparam int unsigned DEF_N_ANTS = 8;
  localparam int unsigned DEF_N_TAPS = n_taps(DEF_N_ANTS);
  localparam int unsigned DEF_N_BLS  = n_bls(DEF_N_ANTS);

endpackage

// File: rtl/xeng_delay_line.sv
// Resettable fixed-depth shift register.
module xeng_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/xeng_bl_order_gen_mc.sv
// Labels every X-engine output word with antenna pair, channel and baseline index,
// with multi-channel interleave, configurable output latency and unsync error flag.
module xeng_bl_order_gen_mc
  import xeng_pkg::*;
#(
  parameter  int unsigned N_ANTS      = 8,
  parameter  int unsigned N_CHANS     = 1,
  parameter  int unsigned OUT_LATENCY = 1,
  localparam int unsigned ANT_BITS    = clog2_min1(N_ANTS),
  localparam int unsigned BL_BITS     = $clog2(n_bls(N_ANTS)),
  localparam int unsigned CH_BITS     = clog2_min1(N_CHANS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sync,
  input  logic                en,
  output logic [ANT_BITS-1:0] ant_a,
  output logic [ANT_BITS-1:0] ant_b,
  output logic                buf_sel,
  output logic                dup,
  output logic [CH_BITS-1:0]  chan,
  output logic [BL_BITS-1:0]  bl_idx,
  output logic                last,
  output logic                vld_out,
  output logic                sync_out,
  output logic                err_unsync
);

  localparam int unsigned N_TAPS = n_taps(N_ANTS);
  localparam int unsigned AW1    = ANT_BITS + 1;

  // Label widths follow the module parameters, so the type is declared here.
  typedef struct packed {
    logic [ANT_BITS-1:0] ant_a;
    logic [ANT_BITS-1:0] ant_b;
    logic                buf_sel;
    logic                dup;
    logic [CH_BITS-1:0]  chan;
    logic [BL_BITS-1:0]  bl_idx;
    logic                last;
  } bl_label_t;

  typedef struct packed {
    logic      vld;
    logic      sync;
    logic      err;
    bl_label_t label;
  } pipe_t;

  logic [ANT_BITS-1:0] a, t, cur_a, cur_t, nxt_a, nxt_t;
  logic [CH_BITS-1:0]  ch, cur_ch, nxt_ch;
  logic [BL_BITS-1:0]  bl, cur_bl, nxt_bl;
  logic                armed;
  logic                accept, a_wrap, t_wrap, ch_wrap;
  logic [ANT_BITS:0]   wrap_sum;
  bl_label_t           cur_label, label_hold;
  pipe_t               pipe_in, pipe_out;

  // sync zeroes the counters before the same-cycle word is labelled.
  always_comb begin
    cur_a   = sync ? '0 : a;
    cur_t   = sync ? '0 : t;
    cur_ch  = sync ? '0 : ch;
    cur_bl  = sync ? '0 : bl;
    accept  = en && (armed || sync);
    a_wrap  = (cur_a == ANT_BITS'(N_ANTS - 1));
    t_wrap  = (cur_t == ANT_BITS'(N_TAPS - 1));
    ch_wrap = (cur_ch == CH_BITS'(N_CHANS - 1));

    wrap_sum            = {1'b0, cur_a} + AW1'(N_ANTS) - {1'b0, cur_t};
    cur_label.ant_a     = cur_a;
    cur_label.buf_sel   = (cur_a < cur_t);
    cur_label.ant_b     = cur_label.buf_sel ? wrap_sum[ANT_BITS-1:0] : (cur_a - cur_t);
    cur_label.dup       = t_wrap && (cur_a >= ANT_BITS'(N_ANTS / 2));
    cur_label.chan      = cur_ch;
    cur_label.bl_idx    = cur_bl;
    cur_label.last      = a_wrap && t_wrap && ch_wrap;

    nxt_a  = cur_a;
    nxt_t  = cur_t;
    nxt_ch = cur_ch;
    nxt_bl = cur_bl;
    if (accept) begin
      nxt_a  = a_wrap ? '0 : cur_a + 1'b1;
      nxt_bl = (a_wrap && t_wrap) ? '0 : cur_bl + 1'b1;
      if (a_wrap) begin
        nxt_t = t_wrap ? '0 : cur_t + 1'b1;
        if (t_wrap) nxt_ch = ch_wrap ? '0 : cur_ch + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a          <= '0;
      t          <= '0;
      ch         <= '0;
      bl         <= '0;
      armed      <= 1'b0;
      label_hold <= '0;
    end else begin
      a  <= nxt_a;
      t  <= nxt_t;
      ch <= nxt_ch;
      bl <= nxt_bl;
      if (sync) armed <= 1'b1;
      if (accept) label_hold <= cur_label;
    end
  end

  // Fields re-send the last accepted label so outputs hold while vld_out is low.
  always_comb begin
    pipe_in       = '0;
    pipe_in.vld   = accept;
    pipe_in.sync  = sync;
    pipe_in.err   = en && !armed && !sync;
    pipe_in.label = accept ? cur_label : label_hold;
  end

  xeng_delay_line #(
    .WIDTH ($bits(pipe_t)),
    .DEPTH (OUT_LATENCY)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pipe_in),
    .q     (pipe_out)
  );

  assign ant_a      = pipe_out.label.ant_a;
  assign ant_b      = pipe_out.label.ant_b;
  assign buf_sel    = pipe_out.label.buf_sel;
  assign dup        = pipe_out.label.dup;
  assign chan       = pipe_out.label.chan;
  assign bl_idx     = pipe_out.label.bl_idx;
  assign last       = pipe_out.label.last;
  assign vld_out    = pipe_out.vld;
  assign sync_out   = pipe_out.sync;
  assign err_unsync = pipe_out.err;

endmodule
